// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: turns raw PS/2 set-2 scancode bytes into complete key events.
// E0/F0 prefixes are folded into pending flags, each key code drives one
// registered table lookup, and the finished event is held on a valid/ready port.
module kbd_event_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       scan_ready,
    output logic [7:0] lut_addr,
    input  logic [7:0] lut_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic [7:0] evt_ascii,
    output logic       evt_release,
    output logic       evt_ext,
    output logic       evt_repeat,
    output logic [7:0] key_count,
    output logic       shift_held
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CAPTURE,
        ST_EMIT
    } state_t;

    state_t     state_q,   state_d;
    logic [7:0] lut_addr_q, lut_addr_d;
    logic [7:0] code_q,    code_d;
    logic [7:0] ascii_q,   ascii_d;
    logic       release_q, release_d;
    logic       ext_q,     ext_d;
    logic       repeat_q,  repeat_d;
    logic       valid_q,   valid_d;
    logic [7:0] count_q,   count_d;
    logic       shift_q,   shift_d;
    logic [8:0] held_q,    held_d;
    logic       pend_ext_q, pend_ext_d;
    logic       pend_brk_q, pend_brk_d;

    // Held-key identity is the code together with its extended flag.
    logic [8:0] cap_key;
    logic       cap_repeat;
    logic       lut_is_lower;

    assign cap_key      = {pend_ext_q, code_q};
    assign cap_repeat   = !pend_brk_q && (cap_key == held_q);
    assign lut_is_lower = (lut_data >= 8'h61) && (lut_data <= 8'h7A);

    // Next-state, event capture and key-state tracking.
    always_comb begin
        state_d    = state_q;
        lut_addr_d = lut_addr_q;
        code_d     = code_q;
        ascii_d    = ascii_q;
        release_d  = release_q;
        ext_d      = ext_q;
        repeat_d   = repeat_q;
        valid_d    = valid_q;
        count_d    = count_q;
        shift_d    = shift_q;
        held_d     = held_q;
        pend_ext_d = pend_ext_q;
        pend_brk_d = pend_brk_q;

        case (state_q)
            ST_IDLE: begin
                if (scan_valid) begin
                    if (scan_code == 8'hE0) begin
                        pend_ext_d = 1'b1;
                    end else if (scan_code == 8'hF0) begin
                        pend_brk_d = 1'b1;
                    end else begin
                        lut_addr_d = scan_code;
                        code_d     = scan_code;
                        state_d    = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                release_d = pend_brk_q;
                ext_d     = pend_ext_q;
                repeat_d  = cap_repeat;
                // Shift state used here is the one before this event.
                if (pend_ext_q) begin
                    ascii_d = '0;
                end else if (shift_q && lut_is_lower) begin
                    ascii_d = lut_data - 8'h20;
                end else begin
                    ascii_d = lut_data;
                end
                if (!pend_brk_q && !cap_repeat) begin
                    held_d  = cap_key;
                    count_d = count_q + 8'd1;
                end else if (pend_brk_q && (cap_key == held_q)) begin
                    held_d = '0;
                end
                if (!pend_ext_q && ((code_q == 8'h12) || (code_q == 8'h59))) begin
                    shift_d = !pend_brk_q;
                end
                pend_ext_d = 1'b0;
                pend_brk_d = 1'b0;
                valid_d    = 1'b1;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                if (valid_q && evt_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and event registers; reset discards any partial prefix or event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lut_addr_q <= '0;
            code_q     <= '0;
            ascii_q    <= '0;
            release_q  <= 1'b0;
            ext_q      <= 1'b0;
            repeat_q   <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            shift_q    <= 1'b0;
            held_q     <= '0;
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lut_addr_q <= lut_addr_d;
            code_q     <= code_d;
            ascii_q    <= ascii_d;
            release_q  <= release_d;
            ext_q      <= ext_d;
            repeat_q   <= repeat_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            held_q     <= held_d;
            pend_ext_q <= pend_ext_d;
            pend_brk_q <= pend_brk_d;
        end
    end

    assign scan_ready  = (state_q == ST_IDLE);
    assign lut_addr    = lut_addr_q;
    assign evt_valid   = valid_q;
    assign evt_code    = code_q;
    assign evt_ascii   = ascii_q;
    assign evt_release = release_q;
    assign evt_ext     = ext_q;
    assign evt_repeat  = repeat_q;
    assign key_count   = count_q;
    assign shift_held  = shift_q;

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Sequencing controller between the PS/2 scancode receiver and the registered scancode-to-ASCII lookup table. It consumes raw set-2 scancode bytes, strips the `E0` and `F0` prefixes, and drives one lookup per key code. It tracks the Shift and held-key state, then emits one complete key event per non-prefix code over a valid/ready handshake. The downstream consumer is the keyboard display/terminal logic.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scan_valid`  in  1  receiver has a scancode byte.
- `scan_code`  in  8  scancode byte.
- `scan_ready`  out  1  controller accepts a byte this cycle.
- `lut_addr`  out  8  registered address to the lookup table.
- `lut_data`  in  8  lookup table output; valid 1 cycle after `lut_addr` is sampled. The table returns lowercase ASCII, or `0x00` if the code is unmapped.
- `evt_valid`  out  1  key event available.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_code`  out  8  key scancode, with prefixes stripped.
- `evt_ascii`  out  8  final ASCII after Shift and extended rules.
- `evt_release`  out  1  event is a break (release).
- `evt_ext`  out  1  event had the `E0` prefix.
- `evt_repeat`  out  1  make event for the key already held (typematic).
- `key_count`  out  8  count of non-repeat make events; wraps from 255 to 0.
- `shift_held`  out  1  current Shift state.

## Operation
- FSM states:
  - IDLE
  - LOOKUP: the lookup table samples `lut_addr`.
  - CAPTURE: `lut_data` is valid.
  - EMIT
- `scan_ready` = 1 only in IDLE.
- IDLE behaviour on an accepted byte:
  - `E0`: set the pending ext flag and stay in IDLE.
  - `F0`: set the pending brk flag and stay in IDLE.
  - Any other byte: `lut_addr` <= byte, `evt_code` <= byte, then go to LOOKUP.
- LOOKUP always goes to CAPTURE.
- CAPTURE, evaluated at the clock edge:
  - `evt_release` <= brk.
  - `evt_ext` <= ext.
  - ASCII rule: `evt_ascii` <= `0x00` if ext. Otherwise it is `lut_data - 0x20` if `shift_held` and `lut_data` is in 0x61..0x7A. Otherwise it is `lut_data`. The rule uses `shift_held` from before this event.
  - Repeat rule: `evt_repeat` <= !brk && {ext, code} == held.
  - Update held and count:
    - Make, not repeat: held <= {ext, code}; `key_count` += 1.
    - Break with {ext, code} == held: held <= 0.
  - Shift: a non-ext code 0x12 or 0x59 sets `shift_held` on make and clears it on break.
  - Clear the pending flags; `evt_valid` <= 1; go to EMIT.
- EMIT: hold all `evt_*` outputs stable. On `evt_valid && evt_ready`: `evt_valid` <= 0 and go to IDLE.
- Prefix rules:
  - Prefixes accumulate in any order.
  - A repeated prefix is idempotent.
  - `E1` is treated as an ordinary code.
- `lut_addr` holds its last value outside LOOKUP.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE.
  - `scan_ready` = 1.
  - `lut_addr` = 0.
  - `evt_*` = 0.
  - `key_count` = 0.
  - `shift_held` = 0.
  - held = 0.
  - Pending flags cleared.
- Latency: code accepted at edge E, then `evt_valid` = 1 after edge E+2.
- Earliest next acceptance is at the edge after the `evt` handshake.
- Maximum throughput is 1 event per 4 cycles with `evt_ready` tied high; each prefix adds 1 cycle.
- Backpressure: while `evt_ready` = 0, the controller stays in EMIT indefinitely and `scan_ready` = 0. The receiver buffers incoming bytes.
- Reset asserted mid-sequence aborts immediately. Any partially captured prefix or event is discarded and no event is emitted.
- `key_count` wraps from 255 to 0 on the 256th counted make.

## Test plan
- Reset, then input `1C` (table maps it to `0x61`) → `evt_valid` after 2 edges. Required outputs: `evt_code` = `1C`, `evt_ascii` = `0x61`, release = 0, ext = 0, repeat = 0, `key_count` = 1.
- Input `12`, then `1C`, then `F0 1C`, then `F0 12`, then `1C`. Required ASCII sequence: `1C` → `0x41`, its break → `0x41`, final `1C` → `0x61`. `shift_held` must go 1 then 0.
- Input `E0 75`, then `E0 F0 75` → first event: ext = 1, ascii = `0x00`, release = 0. Second event: ext = 1, release = 1.
- Input `15 15 15`, then `F0 15`, then `15` → repeat flags 0, 1, 1 for the three makes; the break; then repeat = 0 on the final make. `key_count` increments only on the first and last makes.
- Hold `evt_ready` = 0 for 10 cycles with `scan_valid` = 1 → `scan_ready` = 0 and `evt_*` outputs stable throughout. Exactly one event is consumed when `evt_ready` rises.
- Assert `rst_n` = 0 during CAPTURE after an `F0` prefix → all outputs return to reset values. A following `1C` yields a make event, not a break.
- Input 256 non-repeat makes, alternating `1C` / `1B` → `key_count` reads 0.
